// File: rtl/hv_adc_avg_mch.sv
// Multi-channel HV ADC sampler: per-channel strobe synchroniser, capture, and
// sliding-window floor average over 2^sel samples, with raw bypass.

module hv_adc_avg_ch #(
    parameter int ADC_DW   = 10,
    parameter int AVG_MAX  = 8,
    parameter int SYNC_STG = 2,
    parameter int LG_MAX   = $clog2(AVG_MAX),
    parameter int SEL_DW   = $clog2(LG_MAX + 1),
    parameter int SUM_DW   = ADC_DW + LG_MAX
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rdy,
    input  logic [ADC_DW-1:0] i_data,
    input  logic [SEL_DW-1:0] i_lg,
    input  logic              i_bypass,
    input  logic              i_clr,
    output logic [ADC_DW-1:0] o_data,
    output logic              o_vld,
    output logic              o_full
);
    logic [SYNC_STG-1:0]             sync_q, sync_d;
    logic                            edge_q, edge_d;
    logic [AVG_MAX-1:0][ADC_DW-1:0]  buf_q, buf_d;
    logic [LG_MAX-1:0]               wptr_q, wptr_d;
    logic [LG_MAX:0]                 fill_q, fill_d;
    logic [SUM_DW-1:0]               sum_q, sum_d;
    logic                            upd_q, upd_d;
    logic                            byp_q, byp_d;
    logic [ADC_DW-1:0]               raw_q, raw_d;
    logic [ADC_DW-1:0]               data_q, data_d;
    logic                            vld_q, vld_d;
    logic                            full_q, full_d;
    logic                            cap;
    logic [LG_MAX:0]                 n_win;
    logic [LG_MAX-1:0]               old_idx;

    always_comb begin
        sync_d  = {sync_q[SYNC_STG-2:0], i_rdy};
        edge_d  = sync_q[SYNC_STG-1];
        cap     = sync_q[SYNC_STG-1] & ~edge_q;
        n_win   = (LG_MAX + 1)'(1) << i_lg;
        // Oldest sample in the window; wraps naturally in LG_MAX bits.
        old_idx = wptr_q - n_win[LG_MAX-1:0];

        buf_d  = buf_q;
        wptr_d = wptr_q;
        fill_d = fill_q;
        sum_d  = sum_q;
        upd_d  = 1'b0;
        byp_d  = byp_q;
        raw_d  = raw_q;
        if (i_clr) begin
            wptr_d = '0;
            fill_d = '0;
            sum_d  = '0;
        end else if (cap) begin
            buf_d[wptr_q] = i_data;
            wptr_d        = wptr_q + 1'b1;
            if (fill_q == n_win) begin
                sum_d  = sum_q + SUM_DW'(i_data) - SUM_DW'(buf_q[old_idx]);
                fill_d = n_win;
            end else begin
                sum_d  = sum_q + SUM_DW'(i_data);
                fill_d = fill_q + 1'b1;
            end
            upd_d = 1'b1;
            byp_d = i_bypass;
            raw_d = i_data;
        end
        full_d = (fill_d == n_win);

        vld_d  = 1'b0;
        data_d = data_q;
        if (upd_q) begin
            if (byp_q) begin
                vld_d  = 1'b1;
                data_d = raw_q;
            end else if (fill_q == n_win) begin
                vld_d  = 1'b1;
                data_d = ADC_DW'(sum_q >> i_lg);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
            buf_q  <= '0;
            wptr_q <= '0;
            fill_q <= '0;
            sum_q  <= '0;
            upd_q  <= 1'b0;
            byp_q  <= 1'b0;
            raw_q  <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
            full_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            edge_q <= edge_d;
            buf_q  <= buf_d;
            wptr_q <= wptr_d;
            fill_q <= fill_d;
            sum_q  <= sum_d;
            upd_q  <= upd_d;
            byp_q  <= byp_d;
            raw_q  <= raw_d;
            data_q <= data_d;
            vld_q  <= vld_d;
            full_q <= full_d;
        end
    end

    assign o_data = data_q;
    assign o_vld  = vld_q;
    assign o_full = full_q;
endmodule

module hv_adc_avg_mch #(
    parameter int CH_NUM   = 2,
    parameter int ADC_DW   = 10,
    parameter int AVG_MAX  = 8,
    parameter int SYNC_STG = 2,
    parameter int LG_MAX   = $clog2(AVG_MAX),
    parameter int SEL_DW   = $clog2(LG_MAX + 1),
    parameter int SUM_DW   = ADC_DW + LG_MAX
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [CH_NUM-1:0]        i_adc_rdy,
    input  logic [CH_NUM*ADC_DW-1:0] i_adc_data,
    input  logic [SEL_DW-1:0]        i_avg_sel,
    input  logic                     i_bypass,
    input  logic                     i_clr,
    output logic [CH_NUM*ADC_DW-1:0] o_adc_data,
    output logic [CH_NUM-1:0]        o_adc_vld,
    output logic [CH_NUM-1:0]        o_win_full
);
    logic [SEL_DW-1:0] lg_q, lg_d;
    logic              clr_all;

    always_comb begin
        lg_d    = (i_avg_sel > SEL_DW'(LG_MAX)) ? SEL_DW'(LG_MAX) : i_avg_sel;
        // A window-size change restarts every channel from an empty window.
        clr_all = i_clr | (lg_d != lg_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) lg_q <= '0;
        else          lg_q <= lg_d;
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        hv_adc_avg_ch #(
            .ADC_DW  (ADC_DW),
            .AVG_MAX (AVG_MAX),
            .SYNC_STG(SYNC_STG),
            .LG_MAX  (LG_MAX),
            .SEL_DW  (SEL_DW),
            .SUM_DW  (SUM_DW)
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_rdy   (i_adc_rdy[c]),
            .i_data  (i_adc_data[c*ADC_DW +: ADC_DW]),
            .i_lg    (lg_q),
            .i_bypass(i_bypass),
            .i_clr   (clr_all),
            .o_data  (o_adc_data[c*ADC_DW +: ADC_DW]),
            .o_vld   (o_adc_vld[c]),
            .o_full  (o_win_full[c])
        );
    end
endmodule

// File: doc/hv_adc_avg_mch.md
Name: hv_adc_avg_mch

Overview:
- Multi-channel HV ADC sample capture and boxcar-average block.
- Each channel:
  - synchronises its analog ready strobe into i_clk;
  - captures the ADC word on the strobe's rising edge;
  - keeps a sliding window of the last N samples;
  - outputs the floor mean with a one-cycle valid pulse.
- Sits between the analog ADC front-end and the HV protection/telemetry logic.
- Adds over the previous fixed 2-channel/4-deep sampler:
  - runtime-selectable window;
  - bypass mode;
  - window-fill tracking;
  - per-channel valid.

Parameters:
- CH_NUM, 2, number of independent ADC channels (>=1).
- ADC_DW, 10, ADC sample width in bits.
- AVG_MAX, 8, maximum window depth; power of two, >=2.
- SYNC_STG, 2, synchroniser flop stages on each ready input (>=2).
- Derived: LG_MAX = $clog2(AVG_MAX); SEL_DW = $clog2(LG_MAX+1); SUM_DW = ADC_DW+LG_MAX.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_adc_rdy  in  CH_NUM  per-channel analog data-ready strobe; asynchronous to i_clk.
- i_adc_data  in  CH_NUM*ADC_DW  per-channel sample; channel c at [c*ADC_DW +: ADC_DW]; quasi-static while its rdy is high.
- i_avg_sel  in  SEL_DW  window N = 2^i_avg_sel; values > LG_MAX clamp to AVG_MAX.
- i_bypass  in  1  1 = output latest raw sample each strobe; 0 = averaging.
- i_clr  in  1  synchronous clear of all channel windows.
- o_adc_data  out  CH_NUM*ADC_DW  per-channel result, held between updates.
- o_adc_vld  out  CH_NUM  per-channel one-cycle pulse when o_adc_data updates.
- o_win_full  out  CH_NUM  per-channel level: the window holds N samples.

Behaviour:
- Clock and reset: reset i_rst_n, asynchronous, active-low; clock i_clk.
- Reset values (all zero):
  - o_adc_data, o_adc_vld, o_win_full;
  - synchroniser flops;
  - edge flops;
  - buffers, pointers, fill counters, sums.
- Strobe synchronisation: each i_adc_rdy[c] goes through SYNC_STG flops, then an edge-detect flop.
  - cap[c] = sync & ~sync_d.
  - Exactly one cap per low-to-high transition. A held-high rdy produces no further caps.
- Capture, cycle k (cap[c] high):
  - i_adc_data slice written to buf[c][wptr].
  - wptr increments mod AVG_MAX.
  - fill increments, saturating at N.
- Running sum:
  - If fill < N: sum <= sum + new.
  - If fill == N: sum <= sum + new − buf[c][(wptr − N) mod AVG_MAX].
  - Arithmetic is unsigned, SUM_DW wide; overflow cannot occur.
- Output, registered at the end of cycle k+1; visible with o_adc_vld in cycle k+2:
  - Averaging mode: vld pulses only when the post-update fill == N. Data = sum[LG(N) +: ADC_DW] (floor, no rounding).
  - Before the window is full: no vld, o_adc_data holds its previous value.
  - Bypass mode: vld on every cap, data = the captured sample. Buffer, sum and fill still update so that switching back to averaging is seamless.
- o_win_full[c] = (fill == N), registered.
- Clearing:
  - i_clr, or any change of effective N (registered compare), zeroes wptr, fill and sum for all channels.
  - The clear is applied in the same cycle; a cap in that cycle is discarded.
  - o_adc_data holds; o_win_full drops next cycle.
- Channel independence: channels fully independent; simultaneous caps on different channels are all processed with no mutual stall.
- Throughput: back-to-back caps on one channel every 2 cycles (the minimum edge spacing) must be sustained. Each cap produces its own vld.
- Mid-operation reset: asynchronous assertion returns everything to reset values immediately. The first post-reset average requires N fresh samples.

Test Plan:
- Reset, then N=4 (sel=2), ch0 samples 100, 200, 300, 400 → no vld for the first three; fourth gives o_adc_vld[0] at cap+2 with data 250 and o_win_full[0]=1.
- Continue with 500 → data 350 (200+300+400+500 floor /4). Then 1 → 300. Ch1 idle: o_adc_vld[1] stays 0.
- N=8, eight samples of 1023 → data 1023, no overflow. Then samples 0,0,0 → 639 (5*1023/8 floor).
- Bypass=1, samples 7 then 9 → vld every cap with data 7 then 9. Set bypass=0 with N=2 already full → next sample 11 gives 10.
- Change i_avg_sel 2→1 mid-stream → o_win_full drops. Next sample gives no vld; second sample gives the mean of the two. Repeat the check using i_clr instead of the select change.
- Assert i_rst_n low for 1 cycle after 3 of 4 samples → all outputs 0. Four fresh samples of 40 are required before vld, with data 40. Include a held-high rdy check: only one cap.
